// File: rtl/axis_packet_stream_out.sv
// Packet store-and-forward buffer: accepts AXIS beats, releases only whole committed
// packets as a continuous burst, and discards dropped or oversize packets.
module axis_packet_stream_out #(
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned LOG2_DEPTH     = 8,
  parameter int unsigned GAP_CYCLES     = 0
) (
  input  logic                      clk,
  input  logic                      aresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_drop,
  output logic                      o_valid,
  output logic                      o_last,
  output logic [AXIS_BYTES*8-1:0]   o_data,
  output logic [AXIS_USER_BITS-1:0] o_user,
  output logic                      o_dropped
);

  localparam int unsigned Depth = 2 ** LOG2_DEPTH;
  localparam int unsigned DataW = AXIS_BYTES * 8;
  localparam int unsigned PtrW  = LOG2_DEPTH + 1;
  localparam int unsigned GapW  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

  logic [DataW-1:0]          mem_data [Depth];
  logic [AXIS_USER_BITS-1:0] mem_user [Depth];
  logic                      mem_last [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  state_e          state_q, state_d;
  logic            discard_q, discard_d, dropped_q, dropped_d, ready_en_q;
  logic            o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [DataW-1:0]          o_data_q, o_data_d;
  logic [AXIS_USER_BITS-1:0] o_user_q, o_user_d;

  logic full, overflow, accept, drop_eff, wr_en, commit, pkt_dec, rd_last, gap_done;
  logic [LOG2_DEPTH-1:0] wr_idx, rd_idx;

  assign wr_idx   = wr_ptr_q[LOG2_DEPTH-1:0];
  assign rd_idx   = rd_ptr_q[LOG2_DEPTH-1:0];
  assign rd_last  = mem_last[rd_idx];
  assign full     = (wr_ptr_q - rd_ptr_q) == PtrW'(Depth);
  // The packet in progress alone occupies the whole buffer: it can never complete.
  assign overflow = (wr_ptr_q - cmt_ptr_q) == PtrW'(Depth);
  assign axis_i_tready = ready_en_q & (~full | discard_q | overflow);
  assign accept   = axis_i_tvalid & axis_i_tready;
  assign drop_eff = discard_q | axis_i_drop | overflow;
  // The IDLE and first STREAM cycles also count toward the gap, so GAP holds one cycle less.
  assign gap_done = (32'(gap_cnt_q) + 32'd2) >= GAP_CYCLES;

  // Write side: append, commit on tlast, or rewind a discarded packet.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    discard_d = discard_q;
    dropped_d = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    if (accept) begin
      if (drop_eff) begin
        if (axis_i_tlast) begin
          wr_ptr_d  = cmt_ptr_q;
          discard_d = 1'b0;
          dropped_d = 1'b1;
        end else begin
          discard_d = 1'b1;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (axis_i_tlast) begin
          cmt_ptr_d = wr_ptr_q + PtrW'(1);
          commit    = 1'b1;
        end
      end
    end
  end

  // Read FSM: stream one committed packet per visit, then enforce the inter-packet gap.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_dec   = 1'b0;
    o_valid_d = 1'b0;
    o_last_d  = 1'b0;
    o_data_d  = o_data_q;
    o_user_d  = o_user_q;
    unique case (state_q)
      StIdle: begin
        if (pkt_cnt_q != '0) state_d = StStream;
      end
      StStream: begin
        o_valid_d = 1'b1;
        o_last_d  = rd_last;
        o_data_d  = mem_data[rd_idx];
        o_user_d  = mem_user[rd_idx];
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
        if (rd_last) begin
          pkt_dec = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_done) state_d = StIdle;
        else          gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Complete-packet count: commit and final-beat read may coincide.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({commit, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PtrW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PtrW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Beat storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_idx] <= axis_i_tdata;
      mem_user[wr_idx] <= axis_i_tuser;
      mem_last[wr_idx] <= axis_i_tlast;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      state_q    <= StIdle;
      discard_q  <= 1'b0;
      dropped_q  <= 1'b0;
      ready_en_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_data_q   <= '0;
      o_user_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      state_q    <= state_d;
      discard_q  <= discard_d;
      dropped_q  <= dropped_d;
      ready_en_q <= 1'b1;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
      o_data_q   <= o_data_d;
      o_user_q   <= o_user_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_last    = o_last_q;
  assign o_data    = o_data_q;
  assign o_user    = o_user_q;
  assign o_dropped = dropped_q;

endmodule

// File: tb/tb_axis_packet_stream_out.sv
// Scoreboard bench for axis_packet_stream_out: the driver predicts which packets survive
// and when drops pulse; an independent monitor checks every output cycle.
module tb_axis_packet_stream_out;

  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  typedef struct {
    logic [7:0] d;
    logic [1:0] u;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       axis_i_tready;
  logic       axis_i_tvalid = 1'b0;
  logic       axis_i_tlast = 1'b0;
  logic [7:0] axis_i_tdata = '0;
  logic [1:0] axis_i_tuser = '0;
  logic       axis_i_drop = 1'b0;
  logic       o_valid, o_last, o_dropped;
  logic [7:0] o_data;
  logic [1:0] o_user;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  int    drop_q[$];
  int    last_tlast_cyc = 0;
  int    pkt_start_cyc = 0;
  int    last_gap = 0;
  int    idle_run = 0;
  bit    in_pkt = 0;
  bit    seen_pkt = 0;

  axis_packet_stream_out #(
    .AXIS_BYTES    (1),
    .AXIS_USER_BITS(2),
    .LOG2_DEPTH    (2),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .axis_i_tready(axis_i_tready),
    .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast (axis_i_tlast),
    .axis_i_tdata (axis_i_tdata),
    .axis_i_tuser (axis_i_tuser),
    .axis_i_drop  (axis_i_drop),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_data       (o_data),
    .o_user       (o_user),
    .o_dropped    (o_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Monitor: compares each presented beat against the scoreboard and checks drop pulses.
  always @(negedge clk) begin
    if (!aresetn) begin
      in_pkt   = 0;
      seen_pkt = 0;
      idle_run = 0;
    end else begin
      if (o_last) chk("o_last_needs_valid", o_valid, 1);
      if (o_valid) begin
        if (!in_pkt) begin
          if (seen_pkt) chk("gap_min", (idle_run >= GAP) ? 1 : 0, 1);
          last_gap      = idle_run;
          pkt_start_cyc = cyc;
          in_pkt        = 1;
          seen_pkt      = 1;
        end
        chk("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("o_data", o_data, e.d);
          chk("o_user", o_user, e.u);
          chk("o_last", o_last, e.l);
        end
        if (o_last) in_pkt = 0;
        idle_run = 0;
      end else begin
        if (in_pkt) chk("valid_continuous", o_valid, 1);
        in_pkt = 0;
        idle_run++;
      end
      begin
        bit exp_drop;
        exp_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
        if (exp_drop || o_dropped) begin
          chk("o_dropped", o_dropped, exp_drop);
          if (exp_drop) void'(drop_q.pop_front());
        end
      end
    end
  end

  // Model: a packet survives unless some beat carries drop or it is longer than the buffer.
  task automatic send_pkt(input int len, input int drop_idx, input logic [7:0] base,
                          input int idle_pct, output int stalls);
    bit dropped;
    bit ok;
    dropped = (drop_idx >= 0) || (len > DEPTH);
    stalls  = 0;
    for (int i = 0; i < len; i++) begin
      if (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
        axis_i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = 8'(base + 8'(i));
      axis_i_tuser  = 2'($urandom);
      axis_i_tlast  = (i == len - 1);
      axis_i_drop   = (i == drop_idx);
      if (!dropped) exp_q.push_back('{d: axis_i_tdata, u: axis_i_tuser, l: axis_i_tlast});
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        ok = axis_i_tready;
        if (!ok) stalls++;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      if (!ok) begin
        chk("accept_timeout", 0, 1);
        finish_tb();
      end
    end
    last_tlast_cyc = cyc;
    if (dropped) drop_q.push_back(cyc);
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    axis_i_drop   = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("tready_low_before_edge", axis_i_tready, 0);
    @(posedge clk);
    #1;
    chk("tready_after_first_edge", axis_i_tready, 1);
  endtask

  initial begin
    int st;
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_o_dropped", o_dropped, 0);
    chk("rst_tready", axis_i_tready, 0);
    release_reset();

    // Single 4-beat packet: first beat two edges after the tlast edge.
    send_pkt(4, -1, 8'h10, 0, st);
    chk("pkt4_no_stall", st, 0);
    drain();
    chk("first_valid_latency", pkt_start_cyc - last_tlast_cyc, 2);

    // Two buffered 2-beat packets separated by exactly GAP idle cycles.
    send_pkt(2, -1, 8'h20, 0, st);
    send_pkt(2, -1, 8'h30, 0, st);
    drain();
    chk("gap_exact", last_gap, GAP);

    // Drop on beat 2 of 3, then a clean packet.
    send_pkt(3, 1, 8'h40, 0, st);
    send_pkt(2, -1, 8'h50, 0, st);
    drain();

    // Oversize packet: ready never drops, discarded, followed by a normal packet.
    send_pkt(6, -1, 8'h60, 0, st);
    chk("oversize_no_stall", st, 0);
    send_pkt(2, -1, 8'h70, 0, st);
    drain();

    // Full with a complete packet plus a partial one: backpressure until reads free space.
    send_pkt(1, -1, 8'h80, 0, st);
    send_pkt(2, -1, 8'h90, 0, st);
    send_pkt(3, -1, 8'hA0, 0, st);
    chk("full_backpressure", (st > 0) ? 1 : 0, 1);
    drain();

    // Reset while beat 2 of 4 is on the output.
    send_pkt(4, -1, 8'hB0, 0, st);
    repeat (3) @(posedge clk);
    #2;
    chk("beat2_visible", o_valid, 1);
    aresetn = 1'b0;
    #1;
    chk("reset_kills_valid", o_valid, 0);
    chk("reset_kills_tready", axis_i_tready, 0);
    exp_q.delete();
    drop_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
    repeat (20) @(posedge clk);
    #1;
    send_pkt(2, -1, 8'hC0, 0, st);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      int len;
      int di;
      len = int'($urandom_range(1, 6));
      di  = ($urandom_range(99) < 20) ? int'($urandom_range(0, len - 1)) : -1;
      send_pkt(len, di, 8'($urandom), 30, st);
      if ($urandom_range(3) == 0) repeat (int'($urandom_range(1, 8))) @(posedge clk);
      #1;
    end
    drain();
    chk("drops_all_seen", drop_q.size(), 0);
    finish_tb();
  end

  initial begin
    #400000;
    chk("global_timeout", 0, 1);
    finish_tb();
  end

endmodule
